// File: rtl/ex_mem.sv
// EX/MEM pipeline register: one-cycle EX->MEM latency; flush and stall[3]/stall[4] insert bubbles or hold.
// Also returns the madd/msub partial product and step counter to EX while EX alone is stalled.
module ex_mem #(
    parameter logic [4:0] NOP_REG_ADDR = 5'b00000,
    parameter logic [7:0] ALUOP_NOP    = 8'b00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic [7:0]  mem_aluop,
    output logic [31:0] mem_mem_addr,
    output logic [31:0] mem_reg2,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2;
    } stage_t;

    // Bubble equals sll $0,$0,0: no GPR, HI/LO or memory side effects.
    localparam stage_t BUBBLE = '{
        wd:       NOP_REG_ADDR,
        wreg:     1'b0,
        wdata:    32'd0,
        hi:       32'd0,
        lo:       32'd0,
        whilo:    1'b0,
        aluop:    ALUOP_NOP,
        mem_addr: 32'd0,
        reg2:     32'd0
    };

    stage_t      ex_stage;
    stage_t      mem_stage;
    logic [63:0] hilo_q;
    logic [1:0]  cnt_q;
    logic        ex_stall;
    logic        mem_stall;
    logic        unused_stall;

    assign ex_stall     = stall[3];
    assign mem_stall    = stall[4];
    assign unused_stall = ^{stall[5], stall[2:0]};

    assign ex_stage = '{
        wd:       ex_wd,
        wreg:     ex_wreg,
        wdata:    ex_wdata,
        hi:       ex_hi,
        lo:       ex_lo,
        whilo:    ex_whilo,
        aluop:    ex_aluop,
        mem_addr: ex_mem_addr,
        reg2:     ex_reg2
    };

    // stall[3]=0 with stall[4]=1 never comes from control; it falls into the advance branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_stage <= BUBBLE;
            hilo_q    <= 64'd0;
            cnt_q     <= 2'd0;
        end else if (flush) begin
            mem_stage <= BUBBLE;
            hilo_q    <= 64'd0;
            cnt_q     <= 2'd0;
        end else if (ex_stall && !mem_stall) begin
            // EX is mid-sequence: MEM gets a bubble, partial product loops back.
            mem_stage <= BUBBLE;
            hilo_q    <= hilo_i;
            cnt_q     <= cnt_i;
        end else if (!ex_stall) begin
            mem_stage <= ex_stage;
            hilo_q    <= 64'd0;
            cnt_q     <= 2'd0;
        end
    end

    assign mem_wd       = mem_stage.wd;
    assign mem_wreg     = mem_stage.wreg;
    assign mem_wdata    = mem_stage.wdata;
    assign mem_hi       = mem_stage.hi;
    assign mem_lo       = mem_stage.lo;
    assign mem_whilo    = mem_stage.whilo;
    assign mem_aluop    = mem_stage.aluop;
    assign mem_mem_addr = mem_stage.mem_addr;
    assign mem_reg2     = mem_stage.reg2;
    assign hilo_o       = hilo_q;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed boundary cases followed by a random stream checked with a queue scoreboard.
module tb_ex_mem;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = 6'd0;
    logic        flush = 1'b0;
    ins_t        ex = '0;
    logic [63:0] hilo_i = 64'd0;
    logic [1:0]  cnt_i = 2'd0;

    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic        mem_whilo;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int errors = 0;
    int checks = 0;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex.wd), .ex_wreg(ex.wreg), .ex_wdata(ex.wdata),
        .ex_hi(ex.hi), .ex_lo(ex.lo), .ex_whilo(ex.whilo),
        .ex_aluop(ex.aluop), .ex_mem_addr(ex.addr), .ex_reg2(ex.reg2),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    // Control must never stall MEM without stalling EX.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(stall[4] && !stall[3])) else begin
                errors++;
                $error("FAIL illegal_stall observed=%b expected=stall[4] implies stall[3]", stall);
            end
        end
    end

    function automatic ins_t observed();
        return {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
                mem_aluop, mem_mem_addr, mem_reg2};
    endfunction

    function automatic ins_t rand_ins();
        ins_t r;
        r.wd    = 5'($urandom);
        r.wreg  = 1'($urandom);
        r.wdata = $urandom;
        r.hi    = $urandom;
        r.lo    = $urandom;
        r.whilo = 1'($urandom);
        r.aluop = 8'($urandom);
        r.addr  = $urandom;
        r.reg2  = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input ins_t m, input logic [63:0] h, input logic [1:0] c);
        chk({tag, "_mem"}, 256'(observed()), 256'(m));
        chk({tag, "_hilo"}, 256'(hilo_o), 256'(h));
        chk({tag, "_cnt"}, 256'(cnt_o), 256'(c));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    ins_t        t2;
    ins_t        held;
    ins_t        q[$];
    ins_t        exp_m;
    logic [63:0] exp_h;
    logic [1:0]  exp_c;

    initial begin
        // Reset state, before any clock edge
        #2;
        chk_all("reset", '0, 64'd0, 2'd0);
        step();
        chk_all("reset_hold", '0, 64'd0, 2'd0);
        rst = 1'b1;

        // Basic advance
        t2 = '0;
        t2.wd = 5'd7; t2.wreg = 1'b1; t2.wdata = 32'h1234_5678;
        t2.aluop = 8'h23; t2.addr = 32'h0000_0100;
        ex = t2;
        hilo_i = 64'hDEAD_BEEF_0000_0001;
        cnt_i = 2'd2;
        step();
        chk_all("advance", t2, 64'd0, 2'd0);

        // Asynchronous reset mid-cycle, then hold across 3 edges
        #2 rst = 1'b0;
        #1;
        chk_all("async_reset", '0, 64'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("reset_3edges", '0, 64'd0, 2'd0);
        end
        rst = 1'b1;

        // Bubble into MEM keeps the multi-cycle state, then advance clears it
        ex = t2;
        stall = 6'b001111;
        hilo_i = 64'hFFFF_0000_0000_0001;
        cnt_i = 2'b01;
        step();
        chk_all("ex_stall", '0, 64'hFFFF_0000_0000_0001, 2'd1);
        stall = 6'b000000;
        ex.whilo = 1'b1;
        held = ex;
        step();
        chk_all("madd_release", held, 64'd0, 2'd0);
        chk("madd_whilo", 256'(mem_whilo), 256'(1'b1));

        // Hold for 4 cycles while EX inputs change
        ex = t2;
        step();
        chk_all("load_t2", t2, 64'd0, 2'd0);
        stall = 6'b011111;
        for (int i = 0; i < 4; i++) begin
            ex = rand_ins();
            hilo_i = {$urandom, $urandom};
            cnt_i = 2'($urandom);
            step();
            chk_all("hold", t2, 64'd0, 2'd0);
        end
        stall = 6'b000000;
        held = ex;
        step();
        chk_all("hold_release", held, 64'd0, 2'd0);

        // Flush beats stall
        stall = 6'b001111;
        flush = 1'b1;
        cnt_i = 2'b01;
        hilo_i = 64'h1111_2222_3333_4444;
        step();
        chk_all("flush_over_stall", '0, 64'd0, 2'd0);
        flush = 1'b0;
        stall = 6'b000000;

        // Random stream: every accepted instruction must show up on MEM once, in order
        begin
            int accepted = 0;
            int delivered = 0;
            int cycles = 0;
            logic s3, s4;
            exp_m = observed();
            exp_h = hilo_o;
            exp_c = cnt_o;
            ex = rand_ins();
            while (accepted < 200 && cycles < 5000) begin
                int sel;
                cycles++;
                flush = ($urandom_range(0, 19) == 0);
                sel = $urandom_range(0, 3);
                s3 = (sel >= 2);
                s4 = (sel == 3);
                stall = {1'($urandom), s4, s3, 3'($urandom)};
                hilo_i = {$urandom, $urandom};
                cnt_i = 2'($urandom);
                if (flush) begin
                    exp_m = '0; exp_h = 64'd0; exp_c = 2'd0;
                end else if (s3 && !s4) begin
                    exp_m = '0; exp_h = hilo_i; exp_c = cnt_i;
                end else if (!s3) begin
                    q.push_back(ex);
                    accepted++;
                    exp_h = 64'd0; exp_c = 2'd0;
                end
                step();
                if (!flush && !s3) begin
                    exp_m = q.pop_front();
                    delivered++;
                end
                chk_all("stream", exp_m, exp_h, exp_c);
                // A consumed or flushed EX slot is refilled; a stalled one is held.
                if (flush || !s3) ex = rand_ins();
            end
            chk("stream_budget", 256'(cycles < 5000), 256'(1'b1));
            chk("stream_count", 256'(delivered), 256'(accepted));
            chk("stream_queue_empty", 256'(q.size()), 256'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute (EX) stage and the memory-access (MEM) stage of the 5-stage MIPS32 core.
- Latches EX results, HI/LO write requests and load/store operands on each clock.
- Implements the pipeline stall/flush bubble rules for the EX/MEM boundary.
- Carries the 64-bit partial result and cycle counter for two-cycle madd/maddu/msub/msubu back to EX while EX is stalled.

Parameters:
- NOP_REG_ADDR, 5'b00000, destination register address driven in a bubble
- ALUOP_NOP, 8'b00000000, aluop value driven in a bubble

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- stall  input  6  stall vector from control; stall[3] = EX stalled, stall[4] = MEM stalled
- flush  input  1  pipeline flush from exception control
- ex_wd  input  5  EX destination GPR address
- ex_wreg  input  1  EX GPR write enable
- ex_wdata  input  32  EX GPR write data
- ex_hi  input  32  EX HI write value
- ex_lo  input  32  EX LO write value
- ex_whilo  input  1  EX HI/LO write enable
- ex_aluop  input  8  EX aluop, used by MEM for load/store decode
- ex_mem_addr  input  32  EX computed load/store address
- ex_reg2  input  32  EX store data / lwl-lwr merge operand
- hilo_i  input  64  EX partial madd/msub product
- cnt_i  input  2  EX multi-cycle counter
- mem_wd  output  5  registered ex_wd
- mem_wreg  output  1  registered ex_wreg
- mem_wdata  output  32  registered ex_wdata
- mem_hi  output  32  registered ex_hi
- mem_lo  output  32  registered ex_lo
- mem_whilo  output  1  registered ex_whilo
- mem_aluop  output  8  registered ex_aluop
- mem_mem_addr  output  32  registered ex_mem_addr
- mem_reg2  output  32  registered ex_reg2
- hilo_o  output  64  partial product returned to EX
- cnt_o  output  2  counter returned to EX

Behaviour:
- Reset: asynchronous on rst = 0; no clock edge required.
  - mem_wd = NOP_REG_ADDR, mem_aluop = ALUOP_NOP.
  - mem_wreg, mem_whilo = 0.
  - All 32-bit data outputs = 0; hilo_o = 0; cnt_o = 0.
  - Outputs remain in reset values while rst = 0.
- Release of rst is synchronous to clk through the normal flop path; the first update occurs at the first rising edge with rst = 1.
- All non-reset updates occur on the rising edge with rst = 1. Latency EX -> MEM is 1 cycle. Priority is highest first:
  1. flush = 1: bubble. All mem_* outputs take their reset values; hilo_o = 0; cnt_o = 0. Overrides any stall.
  2. stall[3] = 1 and stall[4] = 0: bubble into MEM. mem_* outputs take their reset values; hilo_o <= hilo_i; cnt_o <= cnt_i. This is the only case that preserves the multi-cycle state.
  3. stall[3] = 1 and stall[4] = 1: hold. All outputs, including hilo_o/cnt_o, keep their values.
  4. stall[3] = 0: advance. All mem_* outputs <= corresponding ex_* inputs; hilo_o <= 0; cnt_o <= 0.
- stall[3] = 0 with stall[4] = 1 is illegal (control never generates it) and is treated as case 4. The verification bench asserts that it never occurs.
- stall bits other than 3 and 4 are ignored.
- Reset asserted mid-operation, e.g. between madd cycles: hilo_o/cnt_o are cleared immediately; EX restarts the sequence.
- No combinational paths input -> output. All outputs are flops.
- Bubble encoding matches an sll $0,$0,0: no GPR write, no HI/LO write, no memory access.

Test Plan:
1. Assert rst = 0 mid-cycle with outputs non-zero -> all outputs 0 and mem_wd = 0 before the next edge; they hold 0 across 3 edges.
2. rst = 1, stall = 0, ex_wd = 5'd7, ex_wreg = 1, ex_wdata = 32'h1234_5678, ex_aluop = 8'h23, ex_mem_addr = 32'h0000_0100 -> after exactly 1 edge, mem_* equal those values; cnt_o = 0, hilo_o = 0.
3. stall = 6'b001111, hilo_i = 64'hFFFF_0000_0000_0001, cnt_i = 2'b01 -> mem_wreg = 0, mem_wd = 0, mem_aluop = 0; hilo_o = 64'hFFFF_0000_0000_0001, cnt_o = 1. Next edge with stall = 0 and ex_whilo = 1 -> hilo_o = 0, cnt_o = 0, mem_whilo = 1.
4. Load outputs as in test 2, then stall = 6'b011111 for 4 cycles while ex_* inputs change -> all outputs stay unchanged. Release stall -> new ex_* values appear after 1 edge.
5. flush = 1 with stall = 6'b001111 and cnt_i = 2'b01 -> all outputs bubble, cnt_o = 0, hilo_o = 0 (flush beats stall).
6. Random back-to-back stream of 200 instructions with random legal stall patterns -> scoreboard confirms:
   - each non-bubbled EX value appears exactly once on mem_*;
   - no value is duplicated or dropped.
